// File: rtl/sdram_wr_burst_feeder.sv
// sdram_wr_burst_feeder: packs pixel bytes into 16-bit words, buffers them in a FIFO
// and issues fixed-length burst write requests with bank/row/column addresses.
module sdram_wr_burst_feeder #(
    parameter int BURST_LEN   = 8,
    parameter int FIFO_DEPTH  = 64,
    parameter int FRAME_WORDS = 153600,
    parameter int COL_W       = 9,
    parameter int ROW_W       = 12
) (
    input  logic                          Sys_clk,
    input  logic                          Rst_n,
    input  logic                          Init_done,
    input  logic                          Sof,
    input  logic                          Din_vld,
    input  logic [7:0]                    Din,
    output logic                          Wr_req,
    input  logic                          Wr_ack,
    output logic [1:0]                    Wr_bank,
    output logic [ROW_W-1:0]              Wr_row,
    output logic [COL_W-1:0]              Wr_col,
    input  logic                          Wr_data_en,
    output logic [15:0]                   Wr_data,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_level,
    output logic                          Ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(BURST_LEN) + 1;
    localparam int LA = COL_W + ROW_W + 2;

    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

    state_t          state, state_nxt;
    logic [15:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   pop_cnt;
    logic [LA-1:0]   lin_addr, addr_q;
    logic [7:0]      lo_byte;
    logic            phase, sof_pend;
    logic            start, pop, done, sof_now, sof_hit, clr, take, push, full, wr_ok;

    assign Wr_req = state == REQ;
    assign {Wr_bank, Wr_row, Wr_col} = addr_q;

    // A Sof outside IDLE (now or earlier) blocks input and is applied when the burst ends
    always_comb begin
        full      = Fifo_level == LW'(FIFO_DEPTH);
        start     = state == IDLE && Init_done && !Sof && Fifo_level >= LW'(BURST_LEN);
        pop       = state == DATA && Wr_data_en;
        done      = pop && pop_cnt == CW'(BURST_LEN - 1);
        sof_now   = state == IDLE && Sof;
        sof_hit   = sof_pend || (Sof && state != IDLE);
        clr       = sof_now || (done && sof_hit);
        take      = Din_vld && !sof_hit;
        push      = take && phase && !sof_now;
        wr_ok     = push && (!full || pop);
        state_nxt = start ? REQ : (state == REQ && Wr_ack) ? DATA : done ? IDLE : state;
    end

    always_ff @(posedge Sys_clk) begin
        if (!Rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge Sys_clk) begin
        if (wr_ok)
            mem[wr_ptr] <= {Din, lo_byte};
    end

    always_ff @(posedge Sys_clk) begin
        if (!Rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            Fifo_level <= '0;
            pop_cnt    <= '0;
            lin_addr   <= '0;
            addr_q     <= '0;
            lo_byte    <= '0;
            phase      <= 1'b0;
            sof_pend   <= 1'b0;
            Wr_data    <= '0;
            Ovf        <= 1'b0;
        end else begin
            sof_pend <= done ? 1'b0 : sof_hit;
            if (start)
                addr_q <= lin_addr;
            if (pop) begin
                Wr_data <= mem[rd_ptr];
                pop_cnt <= done ? '0 : pop_cnt + CW'(1);
            end
            if (clr) begin
                lin_addr   <= '0;
                phase      <= sof_now && Din_vld;
                lo_byte    <= Din;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                Fifo_level <= '0;
            end else begin
                if (done)
                    lin_addr <= lin_addr == LA'(FRAME_WORDS - BURST_LEN) ? '0 : lin_addr + LA'(BURST_LEN);
                if (take) begin
                    phase <= !phase;
                    if (!phase)
                        lo_byte <= Din;
                end
                if (wr_ok)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                Fifo_level <= Fifo_level + LW'(wr_ok) - LW'(pop);
                if (push && !wr_ok)
                    Ovf <= 1'b1;
            end
        end
    end
endmodule
